// File: rtl/ppu_vmem.sv
// ppu_vmem: responder for the PPU video-memory request bus.
// Nametable space ($2000-$3EFF) is served from a 2 KiB CIRAM with cartridge
// mirroring. Pattern space ($0000-$1FFF) is forwarded to the cartridge CHR
// port, whose latency is variable. Palette space ($3F00-$3FFF) is not handled
// here: reads return $00 and writes are discarded. Each request is answered by
// exactly one vmemack pulse.
module ppu_vmem #(
    parameter int          CHR_AW  = 13,
    parameter logic [7:0]  NT_INIT = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [13:0]       vmemaddr,
    input  logic [7:0]        vmemwdata,
    input  logic              vmemwr,
    input  logic              vmemreq,
    output logic              vmemack,
    output logic [7:0]        vmemrdata,
    input  logic [1:0]        mirror,
    input  logic              chrram,
    output logic [CHR_AW-1:0] chraddr,
    output logic [7:0]        chrwdata,
    output logic              chrwr,
    output logic              chrreq,
    input  logic              chrack,
    input  logic [7:0]        chrrdata
);

    typedef enum logic [1:0] {IDLE, NTRD, CHRW, ACK} state_t;

    state_t state_reg;
    state_t state_next;

    // CIRAM is never cleared by reset; the power-up fill only seeds the BRAM.
    logic [7:0] ciram [0:2047] = '{default: NT_INIT};
    logic [7:0] ram_q;

    // Decode of the live request, used only on the accept edge.
    logic        accept;
    logic        is_chr;
    logic        is_pal;
    logic        chr_drop;
    logic        a10;
    logic [10:0] nt_idx;

    // Per-cycle actions produced by the output decoder.
    logic        chr_launch;
    logic        pal_read;
    logic        ram_we;
    logic        ram_capture;
    logic        chr_done;

    // The cycle right after an ack is blocked so a requester that is still
    // releasing vmemreq is not accepted twice.
    assign accept   = (state_reg == IDLE) && vmemreq && !vmemack;
    assign is_chr   = !vmemaddr[13];
    assign is_pal   = (vmemaddr[13:8] == 6'h3F);
    assign chr_drop = is_chr && vmemwr && !chrram;

    // Nametable mirroring: pick which 1 KiB page of CIRAM the address lands in.
    always_comb begin
        a10 = 1'b0;
        case (mirror)
            2'd0:    a10 = vmemaddr[11];
            2'd1:    a10 = vmemaddr[10];
            2'd2:    a10 = 1'b0;
            default: a10 = 1'b1;
        endcase
        nt_idx = {a10, vmemaddr[9:0]};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (is_chr) begin
                        state_next = chr_drop ? ACK : CHRW;
                    end else if (is_pal || vmemwr) begin
                        state_next = ACK;
                    end else begin
                        state_next = NTRD;
                    end
                end
            end
            NTRD:    state_next = ACK;
            CHRW:    state_next = chrack ? ACK : CHRW;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: which datapath actions happen this cycle.
    always_comb begin
        chr_launch  = 1'b0;
        pal_read    = 1'b0;
        ram_we      = 1'b0;
        ram_capture = 1'b0;
        chr_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                chr_launch = accept && is_chr && !chr_drop;
                pal_read   = accept && is_pal && !vmemwr;
                ram_we     = accept && !is_chr && !is_pal && vmemwr;
            end
            NTRD:    ram_capture = 1'b1;
            CHRW:    chr_done    = chrack;
            default: ;
        endcase
    end

    // CIRAM port: writes commit on the accept edge, reads are registered so
    // the data is ready for capture in NTRD.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ciram[nt_idx] <= vmemwdata;
        end
        ram_q <= ciram[nt_idx];
    end

    // Registered bus outputs; the ack pulse follows the cycle spent in ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vmemack   <= 1'b0;
            vmemrdata <= 8'h00;
            chrreq    <= 1'b0;
            chrwr     <= 1'b0;
            chraddr   <= '0;
            chrwdata  <= 8'h00;
        end else begin
            vmemack <= (state_reg == ACK);
            if (chr_launch) begin
                chrreq   <= 1'b1;
                chraddr  <= vmemaddr[CHR_AW-1:0];
                chrwdata <= vmemwdata;
                chrwr    <= vmemwr;
            end
            if (pal_read) begin
                vmemrdata <= 8'h00;
            end
            if (ram_capture) begin
                vmemrdata <= ram_q;
            end
            if (chr_done) begin
                chrreq <= 1'b0;
                if (!chrwr) begin
                    vmemrdata <= chrrdata;
                end
            end
        end
    end

endmodule
